// File: rtl/bmem_burst_reader_pkg.sv
// Shared definitions for the wordline memory burst reader.
//
// Contents:
//   BSIZE / BSIZE_LOG2  - depth of the wordline memory and its address width
//   bmem_rd_req_t       - burst request {addr, len}
//   bmem_rd_rsp_t       - response beat {data, last, err} at the default word width
//   bmem_rd_state_t     - reader FSM states
//   wrap_inc()          - address increment that wraps at BSIZE
//   req_is_legal()      - request legality (addr < BSIZE, 1 <= len <= BSIZE)

package bmem_burst_reader_pkg;

    localparam int unsigned BSIZE      = 10;
    localparam int unsigned BSIZE_LOG2 = 4;
    localparam int unsigned RD_DATA_W  = 32;

    localparam logic [BSIZE_LOG2-1:0] ADDR_MAX = BSIZE_LOG2'(BSIZE - 1);
    localparam logic [BSIZE_LOG2-1:0] LEN_MAX  = BSIZE_LOG2'(BSIZE);

    typedef struct packed {
        logic [BSIZE_LOG2-1:0] addr;
        logic [BSIZE_LOG2-1:0] len;
    } bmem_rd_req_t;

    typedef struct packed {
        logic [RD_DATA_W-1:0] data;
        logic                 last;
        logic                 err;
    } bmem_rd_rsp_t;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDrain,
        StErr
    } bmem_rd_state_t;

    // BSIZE is not a power of two, so the wrap has to be explicit.
    function automatic logic [BSIZE_LOG2-1:0] wrap_inc(input logic [BSIZE_LOG2-1:0] a);
        return (a == ADDR_MAX) ? '0 : a + BSIZE_LOG2'(1);
    endfunction

    function automatic logic req_is_legal(input bmem_rd_req_t req);
        return (req.addr <= ADDR_MAX) && (req.len != '0) && (req.len <= LEN_MAX);
    endfunction

endpackage

// File: rtl/bmem_burst_reader_if.sv
// Bus bundle for the burst reader: request channel, RAM read port and response channel.
//
// Signals:
//   req_valid/req_ready/req_addr/req_len       - burst request handshake
//   mem_rd_en/mem_rd_addr/mem_rd_data          - 1-cycle-latency synchronous RAM read port
//   rsp_valid/rsp_ready/rsp_data/rsp_last/rsp_err - response beat handshake
//
// Modports:
//   slave  - the reader engine (accepts requests, drives the RAM port, returns beats)
//   master - its environment (issues requests, supplies RAM data, consumes beats)

interface bmem_burst_reader_if #(
    parameter int unsigned DATA_W = 32
);
    import bmem_burst_reader_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [BSIZE_LOG2-1:0] req_addr;
    logic [BSIZE_LOG2-1:0] req_len;

    logic                  mem_rd_en;
    logic [BSIZE_LOG2-1:0] mem_rd_addr;
    logic [DATA_W-1:0]     mem_rd_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_last;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_addr, req_len, mem_rd_data, rsp_ready,
        output req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_data, rsp_last, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_len, mem_rd_data, rsp_ready,
        input  req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_data, rsp_last, rsp_err
    );

endinterface

// File: rtl/bmem_rsp_fifo.sv
// Small synchronous FIFO holding response beats for the burst reader.
//
// Parameters:
//   RSP_DEPTH - number of entries (>= 2, need not be a power of two)
//   WIDTH     - entry width
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears pointers, count and storage)
//   push      - write push_data (ignored when full unless a pop happens in the same cycle)
//   pop       - drop the head entry (ignored when empty)
//   pop_data  - head entry
//   full, empty, count - occupancy

module bmem_rsp_fifo #(
    parameter  int unsigned RSP_DEPTH = 2,
    parameter  int unsigned WIDTH     = 34,
    localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);

    logic [WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == CNT_W'(RSP_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so push into a full FIFO is fine then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bmem_burst_reader.sv
// Read-side engine for the BSIZE-deep wordline memory.
//
// Accepts burst requests (start address, length) and issues one read per beat to a
// 1-cycle-latency synchronous RAM, wrapping addresses modulo BSIZE. Returned words pass
// through a small response FIFO; the final beat carries last=1. An illegal request
// (addr >= BSIZE, len == 0 or len > BSIZE) yields a single beat {data=0, last=1, err=1}.
//
// Parameters:
//   DATA_W    - memory word / response data width
//   RSP_DEPTH - response FIFO entries (>= 2)
//
// Ports:
//   clk, rst   - sole clock, asynchronous active-high reset
//   bus        - bmem_burst_reader_if.slave (request, RAM read port, response)
//   stat_beats - popped non-error beats, saturating (only with BMEM_BURST_READER_STATS_EN)
//   stat_errs  - accepted illegal requests, saturating (only with BMEM_BURST_READER_STATS_EN)
//
// Optional feature: define BMEM_BURST_READER_STATS_EN to add the two statistics counters.

module bmem_burst_reader
    import bmem_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    bmem_burst_reader_if.slave bus
`ifdef BMEM_BURST_READER_STATS_EN
    ,
    output logic [15:0]        stat_beats,
    output logic [15:0]        stat_errs
`endif
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned ENT_W = DATA_W + 2;

    bmem_rd_state_t        state_q, state_d;
    logic [BSIZE_LOG2-1:0] cur_addr_q, cur_addr_d;
    logic [BSIZE_LOG2-1:0] remaining_q, remaining_d;
    logic                  inflight_q;
    logic                  last_pending_q;

    bmem_rd_req_t          req;
    logic                  req_legal;
    logic                  issue;
    logic                  err_push;
    logic                  credit_ok;
    logic [31:0]           credit_used;

    logic                  push;
    logic                  pop;
    logic [ENT_W-1:0]      push_data;
    logic [ENT_W-1:0]      head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    assign req.addr  = bus.req_addr;
    assign req.len   = bus.req_len;
    assign req_legal = req_is_legal(req);

    // Slots already taken or promised. The beat leaving this cycle is not counted: its slot
    // is free before the word read now lands, which keeps one beat per cycle at depth 2.
    assign credit_used = 32'(fifo_count) + 32'(inflight_q) - 32'(pop);
    assign credit_ok   = (credit_used < RSP_DEPTH);

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        issue       = 1'b0;
        err_push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (req_legal) begin
                        cur_addr_d  = req.addr;
                        remaining_d = req.len;
                        state_d     = StBurst;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StBurst: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    cur_addr_d  = wrap_inc(cur_addr_q);
                    remaining_d = remaining_q - BSIZE_LOG2'(1);
                    if (remaining_q == BSIZE_LOG2'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!inflight_q) begin
                    state_d = StIdle;
                end
            end
            StErr: begin
                if (!fifo_full) begin
                    err_push = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            cur_addr_q     <= '0;
            remaining_q    <= '0;
            inflight_q     <= 1'b0;
            last_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_addr_q     <= cur_addr_d;
            remaining_q    <= remaining_d;
            inflight_q     <= issue;
            last_pending_q <= issue && (remaining_q == BSIZE_LOG2'(1));
        end
    end

    // Held low during reset even though the state register already reads idle.
    assign bus.req_ready   = (state_q == StIdle) && !rst;
    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = issue ? cur_addr_q : '0;

    // Error beats only occur in StErr, which is never entered with a read in flight.
    assign push      = inflight_q || err_push;
    assign push_data = inflight_q ? {bus.mem_rd_data, last_pending_q, 1'b0}
                                  : {{DATA_W{1'b0}}, 2'b11};
    assign pop       = !fifo_empty && bus.rsp_ready;

    bmem_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH),
        .WIDTH     (ENT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.rsp_valid = !fifo_empty;
    assign {bus.rsp_data, bus.rsp_last, bus.rsp_err} = fifo_empty ? '0 : head;

`ifdef BMEM_BURST_READER_STATS_EN
    logic [15:0] stat_beats_q;
    logic [15:0] stat_errs_q;
    logic        err_accept;

    assign err_accept = (state_q == StIdle) && bus.req_valid && !req_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_beats_q <= '0;
            stat_errs_q  <= '0;
        end else begin
            if (pop && !head[0] && (stat_beats_q != 16'hFFFF)) begin
                stat_beats_q <= stat_beats_q + 16'd1;
            end
            if (err_accept && (stat_errs_q != 16'hFFFF)) begin
                stat_errs_q <= stat_errs_q + 16'd1;
            end
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_errs  = stat_errs_q;
`endif

endmodule

// File: tb/tb_bmem_burst_reader.sv
// Self-checking bench for bmem_burst_reader: reset values, exact burst timing, a table of
// legal/illegal requests, backpressure, reset mid-burst, and randomized traffic against a
// queue-based model of the expected beats and RAM addresses.

module tb_bmem_burst_reader;
    import bmem_burst_reader_pkg::*;

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  len;
        int          n_beats;
        logic        err;
        logic [31:0] first;
        logic [31:0] last_data;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;
    bit   rand_ready = 0;

    logic [31:0]  mem [BSIZE];
    bmem_rd_rsp_t exp_q[$];
    bmem_rd_rsp_t got_q[$];
    logic [3:0]   exp_addr_q[$];
    logic [3:0]   got_addr_q[$];

    bit           stall_prev = 0;
    bmem_rd_rsp_t prev_beat;
    vec_t         vecs [9];

`ifdef BMEM_BURST_READER_STATS_EN
    logic [15:0] stat_beats;
    logic [15:0] stat_errs;
`endif

    bmem_burst_reader_if #(.DATA_W(32)) bus ();

    bmem_burst_reader #(
        .DATA_W    (32),
        .RSP_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef BMEM_BURST_READER_STATS_EN
        ,
        .stat_beats (stat_beats),
        .stat_errs  (stat_errs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs change just after the rising edge, so the falling edge sees stable values.
    always @(negedge clk) begin
        bmem_rd_rsp_t b;
        b = {bus.rsp_data, bus.rsp_last, bus.rsp_err};
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(bus.rsp_valid), 64'(1));
                check("hold_beat", 64'(b), 64'(prev_beat));
            end
            if (bus.rsp_valid && bus.rsp_ready) got_q.push_back(b);
            if (bus.mem_rd_en) got_addr_q.push_back(bus.mem_rd_addr);
            stall_prev = bus.rsp_valid && !bus.rsp_ready;
            prev_beat  = b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    // Expected beats come straight from the request: consecutive words modulo BSIZE.
    task automatic model_req(input logic [3:0] addr, input logic [3:0] len);
        bmem_rd_rsp_t e;
        int unsigned  a;
        if (int'(addr) < int'(BSIZE) && len >= 1 && int'(len) <= int'(BSIZE)) begin
            for (int i = 0; i < int'(len); i++) begin
                a = (int'(addr) + i) % BSIZE;
                exp_addr_q.push_back(4'(a));
                e.data = mem[a];
                e.last = (i == int'(len) - 1);
                e.err  = 1'b0;
                exp_q.push_back(e);
            end
        end else begin
            e.data = '0;
            e.last = 1'b1;
            e.err  = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Returns in the cycle after the accepting edge.
    task automatic send_req(input logic [3:0] addr, input logic [3:0] len);
        bit acc = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = len;
        for (int i = 0; i < 500 && !acc; i++) begin
            acc = bus.req_ready;
            tick();
        end
        bus.req_valid = 1'b0;
        check("req_accept", 64'(acc), 64'(1));
        if (acc) model_req(addr, len);
    endtask

    task automatic drain_wait(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (got_q.size() >= exp_q.size() && bus.req_ready && !bus.rsp_valid) done = 1;
            else tick();
        end
        check("drain_done", 64'(done), 64'(1));
    endtask

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
        exp_addr_q.delete();
        got_addr_q.delete();
    endtask

    task automatic score();
        check("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("beat", 64'(got_q[i]), 64'(exp_q[i]));
        check("read_count", 64'(got_addr_q.size()), 64'(exp_addr_q.size()));
        for (int i = 0; i < got_addr_q.size() && i < exp_addr_q.size(); i++)
            check("read_addr", 64'(got_addr_q[i]), 64'(exp_addr_q[i]));
        clear_queues();
    endtask

    initial begin
        vecs[0] = '{4'd2,  4'd3,  3,  1'b0, 32'hA000_0002, 32'hA000_0004};
        vecs[1] = '{4'd8,  4'd5,  5,  1'b0, 32'hA000_0008, 32'hA000_0002};
        vecs[2] = '{4'd9,  4'd1,  1,  1'b0, 32'hA000_0009, 32'hA000_0009};
        vecs[3] = '{4'd0,  4'd10, 10, 1'b0, 32'hA000_0000, 32'hA000_0009};
        vecs[4] = '{4'd10, 4'd1,  1,  1'b1, 32'h0,         32'h0};
        vecs[5] = '{4'd0,  4'd0,  1,  1'b1, 32'h0,         32'h0};
        vecs[6] = '{4'd0,  4'd11, 1,  1'b1, 32'h0,         32'h0};
        vecs[7] = '{4'd15, 4'd15, 1,  1'b1, 32'h0,         32'h0};
        vecs[8] = '{4'd5,  4'd10, 10, 1'b0, 32'hA000_0005, 32'hA000_0004};

        for (int i = 0; i < int'(BSIZE); i++) mem[i] = 32'hA000_0000 + 32'(i);
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.rsp_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_rd_en", 64'(bus.mem_rd_en), 64'(0));
        check("rst_rd_addr", 64'(bus.mem_rd_addr), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_beat", 64'({bus.rsp_data, bus.rsp_last, bus.rsp_err}), 64'(0));
        rst = 1'b0;
        #1;
        check("idle_req_ready", 64'(bus.req_ready), 64'(1));
        tick();

        // Exact timing of a short burst with the consumer always ready
        bus.rsp_ready = 1'b1;
        send_req(4'd2, 4'd3);
        check("t1_rd_en", 64'(bus.mem_rd_en), 64'(1));
        check("t1_rd_addr", 64'(bus.mem_rd_addr), 64'(2));
        check("t1_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        tick();
        check("t2_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("t2_rd_addr", 64'(bus.mem_rd_addr), 64'(3));
        tick();
        for (int k = 0; k < 3; k++) begin
            check("burst_valid", 64'(bus.rsp_valid), 64'(1));
            check("burst_data", 64'(bus.rsp_data), 64'(32'hA000_0002 + 32'(k)));
            check("burst_last", 64'(bus.rsp_last), 64'(k == 2));
            check("burst_err", 64'(bus.rsp_err), 64'(0));
            tick();
        end
        check("burst_after_valid", 64'(bus.rsp_valid), 64'(0));
        drain_wait(50);
        score();

        // Table of legal, wrapping and illegal requests
        for (int v = 0; v < 9; v++) begin
            send_req(vecs[v].addr, vecs[v].len);
            drain_wait(300);
            check("vec_beats", 64'(got_q.size()), 64'(vecs[v].n_beats));
            if (got_q.size() > 0) begin
                check("vec_first", 64'(got_q[0].data), 64'(vecs[v].first));
                check("vec_last_data", 64'(got_q[$].data), 64'(vecs[v].last_data));
                check("vec_last_flag", 64'(got_q[$].last), 64'(1));
                check("vec_err", 64'(got_q[$].err), 64'(vecs[v].err));
            end
            check("vec_reads", 64'(got_addr_q.size()), 64'(vecs[v].err ? 0 : vecs[v].n_beats));
            check("vec_req_ready", 64'(bus.req_ready), 64'(1));
            score();
        end

        // Backpressure: consumer stalls for 6 cycles, at most RSP_DEPTH reads go out
        bus.rsp_ready = 1'b0;
        send_req(4'd0, 4'd10);
        repeat (6) tick();
        check("bp_reads", 64'(got_addr_q.size() <= 2), 64'(1));
        check("bp_valid", 64'(bus.rsp_valid), 64'(1));
        check("bp_head", 64'(bus.rsp_data), 64'(32'hA000_0000));
        bus.rsp_ready = 1'b1;
        drain_wait(200);
        score();

        // Reset during beat 4 of a 10-beat burst
        send_req(4'd0, 4'd10);
        for (int i = 0; i < 100 && got_q.size() < 3; i++) tick();
        check("mid_beats_seen", 64'(got_q.size()), 64'(3));
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("mid_rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("mid_rst_rd_en", 64'(bus.mem_rd_en), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        clear_queues();
        #1;
        check("mid_rel_req_ready", 64'(bus.req_ready), 64'(1));
        send_req(4'd5, 4'd1);
        drain_wait(50);
        check("mid_fresh_beats", 64'(got_q.size()), 64'(1));
        score();

        // Randomized traffic with random consumer readiness
        for (int i = 0; i < int'(BSIZE); i++) mem[i] = $urandom;
        rand_ready = 1;
        for (int n = 0; n < 40; n++) begin
            logic [3:0] a;
            logic [3:0] l;
            if ($urandom_range(0, 3) != 0) begin
                a = 4'($urandom_range(0, BSIZE - 1));
                l = 4'($urandom_range(1, BSIZE));
            end else begin
                a = 4'($urandom_range(0, 15));
                l = 4'($urandom_range(0, 15));
            end
            send_req(a, l);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 3)) tick();
        end
        drain_wait(5000);
        score();
        rand_ready    = 0;
        bus.rsp_ready = 1'b1;

`ifdef BMEM_BURST_READER_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_queues();
        tick();
        send_req(4'd0, 4'd10);
        send_req(4'd3, 4'd10);
        send_req(4'd12, 4'd1);
        drain_wait(300);
        score();
        check("stat_beats", 64'(stat_beats), 64'(20));
        check("stat_errs", 64'(stat_errs), 64'(1));
        force dut.stat_beats_q = 16'hFFFE;
        #1;
        release dut.stat_beats_q;
        send_req(4'd0, 4'd3);
        drain_wait(100);
        score();
        check("stat_beats_sat", 64'(stat_beats), 64'(16'hFFFF));
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
        $fatal(1, "watchdog");
    end

endmodule
